exec_mem_unit: RTL and testbench

- Combined decode/execute/memory block of the 5-stage pipelined 32-bit RISC core.
- Decodes the ID-stage 4-bit opcode into pipeline control bits.
- Performs the EX-stage ALU operation with EX/M forwarding muxes.
- Holds the M-stage word-addressed data memory, read and written from EX/M-registered signals.

---
 rtl/exec_mem_unit.sv | 91 +++++++++
 tb/tb_exec_mem_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Decode, execute and memory slice of the 5-stage core: ID control decode,
// EX ALU with EX/M forwarding, and the M-stage word-addressed data memory.
module exec_mem_unit #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  output logic              ALU_Src,
  output logic [1:0]        ALU_Op,
  output logic              MR,
  output logic              MW,
  output logic              MReg,
  output logic              EnRW,
  input  logic [DATA_W-1:0] RD1_1,
  input  logic [DATA_W-1:0] RD2_1,
  input  logic [DATA_W-1:0] SignExtended_1,
  input  logic              FA,
  input  logic              FB,
  input  logic              ID_EX_ALU_Src,
  input  logic [1:0]        ID_EX_ALU_Op,
  input  logic [DATA_W-1:0] ALU_Result_1,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              EX_M_MR,
  input  logic              EX_M_MW,
  output logic [DATA_W-1:0] ALU_srcA,
  output logic [DATA_W-1:0] ALU_srcB,
  output logic [DATA_W-1:0] RD2_2,
  output logic [DATA_W-1:0] ALU_Result,
  output logic              Zero,
  output logic [DATA_W-1:0] Mem_Data
);

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_e;

  // Packed as {ALU_Src, ALU_Op[1:0], MR, MW, MReg, EnRW}.
  logic [6:0] ctrl;

  always_comb begin
    ctrl = '0;
    case (opcode)
      4'b0000: ctrl = 7'b0_00_0001;
      4'b0001: ctrl = 7'b0_01_0001;
      4'b0010: ctrl = 7'b0_10_0001;
      4'b0011: ctrl = 7'b0_11_0001;
      4'b0100: ctrl = 7'b1_00_0001;
      4'b0101: ctrl = 7'b1_00_1011;
      4'b0110: ctrl = 7'b1_00_0100;
      default: ctrl = '0;
    endcase
  end

  assign {ALU_Src, ALU_Op, MR, MW, MReg, EnRW} = ctrl;

  // The immediate overrides forwarding on B; RD2_2 keeps the forwarded value for stores.
  assign ALU_srcA = FA ? ALU_Result_1 : RD1_1;
  assign RD2_2    = FB ? ALU_Result_1 : RD2_1;
  assign ALU_srcB = ID_EX_ALU_Src ? SignExtended_1 : RD2_2;

  always_comb begin
    ALU_Result = '0;
    case (alu_op_e'(ID_EX_ALU_Op))
      OP_ADD:  ALU_Result = ALU_srcA + ALU_srcB;
      OP_SUB:  ALU_Result = ALU_srcA - ALU_srcB;
      OP_AND:  ALU_Result = ALU_srcA & ALU_srcB;
      OP_OR:   ALU_Result = ALU_srcA | ALU_srcB;
      default: ALU_Result = '0;
    endcase
  end

  assign Zero = (ALU_Result == '0);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_W-1:0] idx;

  // Byte address; low two bits and bits above the word index are ignored.
  assign idx = ALU_Result_1[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (EX_M_MW) begin
      mem_q[idx] <= Write_Data;
    end
  end

  assign Mem_Data = (EX_M_MR && rst) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized self-checking bench for exec_mem_unit against a behavioural model.
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        ALU_Src, MR, MW, MReg, EnRW;
  logic [1:0]  ALU_Op;
  logic [31:0] RD1_1, RD2_1, SignExtended_1, ALU_Result_1, Write_Data;
  logic        FA, FB, ID_EX_ALU_Src, EX_M_MR, EX_M_MW;
  logic [1:0]  ID_EX_ALU_Op;
  logic [31:0] ALU_srcA, ALU_srcB, RD2_2, ALU_Result, Mem_Data;
  logic        Zero;

  exec_mem_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .ALU_Src(ALU_Src), .ALU_Op(ALU_Op), .MR(MR), .MW(MW), .MReg(MReg), .EnRW(EnRW),
    .RD1_1(RD1_1), .RD2_1(RD2_1), .SignExtended_1(SignExtended_1),
    .FA(FA), .FB(FB), .ID_EX_ALU_Src(ID_EX_ALU_Src), .ID_EX_ALU_Op(ID_EX_ALU_Op),
    .ALU_Result_1(ALU_Result_1), .Write_Data(Write_Data),
    .EX_M_MR(EX_M_MR), .EX_M_MW(EX_M_MW),
    .ALU_srcA(ALU_srcA), .ALU_srcB(ALU_srcB), .RD2_2(RD2_2),
    .ALU_Result(ALU_Result), .Zero(Zero), .Mem_Data(Mem_Data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned model_mem [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Decode expectation as {ALU_Src, ALU_Op, MR, MW, MReg, EnRW}.
  function automatic logic [6:0] exp_ctrl(input int op);
    case (op)
      0: return 7'b0_00_0001;
      1: return 7'b0_01_0001;
      2: return 7'b0_10_0001;
      3: return 7'b0_11_0001;
      4: return 7'b1_00_0001;
      5: return 7'b1_00_1011;
      6: return 7'b1_00_0100;
      default: return 7'b0;
    endcase
  endfunction

  function automatic int unsigned exp_alu(input int op, input int unsigned a, input int unsigned b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Checks every EX-stage output against the model for the current inputs.
  task automatic check_alu(input string tag);
    int unsigned a, r2, b, r;
    a  = FA ? ALU_Result_1 : RD1_1;
    r2 = FB ? ALU_Result_1 : RD2_1;
    b  = ID_EX_ALU_Src ? SignExtended_1 : r2;
    r  = exp_alu(int'(ID_EX_ALU_Op), a, b);
    chk({tag, ".srcA"}, ALU_srcA, a);
    chk({tag, ".srcB"}, ALU_srcB, b);
    chk({tag, ".rd2_2"}, RD2_2, r2);
    chk({tag, ".res"}, ALU_Result, r);
    chk({tag, ".zero"}, {31'b0, Zero}, {31'b0, r == 0});
  endtask

  function automatic int unsigned exp_mem();
    if (EX_M_MR && rst) return model_mem[(ALU_Result_1 >> 2) % 256];
    return 0;
  endfunction

  // One clock edge; the model follows the inputs that were held across it.
  task automatic step();
    @(posedge clk);
    if (!rst) foreach (model_mem[i]) model_mem[i] = 0;
    else if (EX_M_MW) model_mem[(ALU_Result_1 >> 2) % 256] = Write_Data;
    #1;
  endtask

  task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    RD1_1 = a; RD2_1 = b; ID_EX_ALU_Op = op; FA = 0; FB = 0; ID_EX_ALU_Src = 0;
  endtask

  initial begin
    rst = 0; opcode = 0; RD1_1 = 0; RD2_1 = 0; SignExtended_1 = 0;
    FA = 0; FB = 0; ID_EX_ALU_Src = 0; ID_EX_ALU_Op = 0;
    ALU_Result_1 = 0; Write_Data = 0; EX_M_MR = 1; EX_M_MW = 0;
    #2;
    chk("reset_rd_zero", Mem_Data, 32'h0);
    step();
    step();
    rst = 1; EX_M_MR = 1; ALU_Result_1 = 32'd40; #1;
    chk("post_reset_word", Mem_Data, 32'h0);
    EX_M_MR = 0;

    for (int op = 0; op < 16; op++) begin
      opcode = 4'(op); #1;
      chk($sformatf("dec_%0d", op), {25'b0, ALU_Src, ALU_Op, MR, MW, MReg, EnRW}, {25'b0, exp_ctrl(op)});
    end

    set_alu(5, 3, 2'b00); #1; chk("add_5_3", ALU_Result, 8);
    set_alu(5, 3, 2'b01); #1; chk("sub_5_3", ALU_Result, 2);
    set_alu(5, 3, 2'b10); #1; chk("and_5_3", ALU_Result, 1);
    set_alu(5, 3, 2'b11); #1; chk("or_5_3", ALU_Result, 7);
    set_alu(3, 3, 2'b01); #1; chk("sub_3_3", ALU_Result, 0); chk("sub_3_3.zero", {31'b0, Zero}, 1);
    set_alu(32'hFFFFFFFF, 1, 2'b00); #1;
    chk("wrap_add", ALU_Result, 0); chk("wrap_add.zero", {31'b0, Zero}, 1);

    set_alu(1, 2, 2'b00); ALU_Result_1 = 100; FA = 1; #1;
    chk("fwd_a.srcA", ALU_srcA, 100); chk("fwd_a.res", ALU_Result, 102);
    FB = 1; ID_EX_ALU_Src = 1; SignExtended_1 = 4; #1;
    chk("imm_wins.srcB", ALU_srcB, 4); chk("imm_wins.rd2_2", RD2_2, 100);

    for (int i = 0; i < 150; i++) begin
      RD1_1 = $urandom; RD2_1 = ($urandom_range(0, 3) == 0) ? RD1_1 : $urandom;
      SignExtended_1 = $urandom; ALU_Result_1 = $urandom;
      FA = 1'($urandom); FB = 1'($urandom); ID_EX_ALU_Src = 1'($urandom);
      ID_EX_ALU_Op = 2'($urandom); #1;
      check_alu($sformatf("rnd_alu%0d", i));
    end

    ALU_Result_1 = 8; Write_Data = 32'hDEADBEEF; EX_M_MW = 1; EX_M_MR = 0;
    step();
    EX_M_MW = 0; EX_M_MR = 1; #1;
    chk("load_8", Mem_Data, 32'hDEADBEEF);
    ALU_Result_1 = 8 + 1024; #1; chk("load_alias", Mem_Data, 32'hDEADBEEF);
    EX_M_MR = 0; #1; chk("mr_off", Mem_Data, 0);

    ALU_Result_1 = 12; Write_Data = 32'h11; EX_M_MW = 1; step();
    Write_Data = 32'h22; EX_M_MR = 1; #1;
    chk("rw_old", Mem_Data, 32'h11);
    step(); EX_M_MW = 0; #1;
    chk("rw_new", Mem_Data, 32'h22);

    ALU_Result_1 = 4; Write_Data = 32'h55; EX_M_MW = 1; step();
    rst = 0; Write_Data = 32'h99; #1;
    chk("rst_mem_rd", Mem_Data, 0);
    step();
    rst = 1; EX_M_MW = 0; EX_M_MR = 1; #1;
    chk("rst_cleared", Mem_Data, 0);
    ALU_Result_1 = 12; #1; chk("rst_cleared12", Mem_Data, 0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      ALU_Result_1 = {$urandom_range(0, 15) == 0 ? 22'($urandom) : 22'd0,
                      8'($urandom_range(0, 15)), 2'($urandom)};
      Write_Data = $urandom; EX_M_MR = 1'($urandom_range(0, 3) != 0);
      EX_M_MW = 1'($urandom); #1;
      chk($sformatf("rnd_mem%0d", i), Mem_Data, exp_mem());
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
